// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM sequencing one RV32I instruction at a time through the shared datapath.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instret,
    output logic       illegal,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd7
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   legal, is_load, is_store, is_branch, unused;
    // funct3 is consumed by the ALU decoder, not by the sequencing
    assign unused    = ^funct3;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign legal     = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                state_d   = legal ? EXEC : HALT;
                illegal_d = illegal_q | ~legal;
            end
            EXEC: begin
                alu_a_sel = opcode == OP_LUI ? 2'd2 : opcode == OP_AUIPC ? 2'd1 : 2'd0;
                alu_b_sel = opcode != OP_R && !is_branch;
                alu_op    = (opcode == OP_R || opcode == OP_IMM) ? 2'd2 : is_branch ? 2'd1 : 2'd0;
                pc_we     = is_branch;
                pc_sel    = {1'b0, is_branch & branch_taken};
                state_d   = is_branch ? FETCH : (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                pc_we    = is_store & mem_ready;
                state_d  = !mem_ready ? MEM : is_store ? FETCH : WB;
            end
            WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_load ? 2'd1 : (opcode == OP_JAL || opcode == OP_JALR) ? 2'd2 : 2'd0;
                pc_sel  = opcode == OP_JAL ? 2'd1 : opcode == OP_JALR ? 2'd2 : 2'd0;
                state_d = FETCH;
            end
            default: state_d = state_q;
        endcase
        // reset kills every strobe at once so an in-flight request is dropped
        if (rst) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 2'd0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            alu_a_sel = 2'd0;
            alu_b_sel = 1'b0;
            alu_op    = 2'd0;
            rf_we     = 1'b0;
            wb_sel    = 2'd0;
        end
    end
    assign instret = pc_we;
    assign illegal = illegal_q & ~rst;
    assign state   = rst ? 3'd0 : state_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-feature tests of the multicycle control FSM.
module tb_multicycle_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       mem_ready = 1'b0, branch_taken = 1'b0;
    logic       ir_we, pc_we, mem_req, mem_we, addr_sel, alu_b_sel, rf_we, instret, illegal;
    logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel;
    logic [2:0] state;
    int checks = 0, failures = 0;
    int cyc;
    logic rf, mwe, unst, eb;
    logic [1:0] wb, ps, ea, eo;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
        .instret(instret), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Runs one instruction from FETCH (entered at posedge+1) until instret, with wait-state injection.
    task automatic run(input logic [6:0] op, input logic tk, input int fw, input int mw,
                       output int c_o, output logic rf_o, output logic [1:0] wb_o,
                       output logic [1:0] ps_o, output logic mwe_o, output logic unst_o,
                       output logic [1:0] ea_o, output logic eb_o, output logic [1:0] eo_o);
        logic pend, pa, pw;
        c_o = -1; rf_o = 0; wb_o = 0; ps_o = 0; mwe_o = 0; unst_o = 0;
        ea_o = 0; eb_o = 0; eo_o = 0; pend = 0; pa = 0; pw = 0;
        opcode = op;
        branch_taken = tk;
        for (int c = 1; c <= 40; c++) begin
            if (state == 3'd0 && fw > 0) begin mem_ready = 0; fw--; end
            else if (state == 3'd3 && mw > 0) begin mem_ready = 0; mw--; end
            else mem_ready = 1;
            #2;
            if (pend && (!mem_req || addr_sel !== pa || mem_we !== pw)) unst_o = 1;
            pend = mem_req && !mem_ready;
            pa = addr_sel;
            pw = mem_we;
            if (state == 3'd2) begin ea_o = alu_a_sel; eb_o = alu_b_sel; eo_o = alu_op; end
            if (rf_we) begin rf_o = 1; wb_o = wb_sel; end
            if (mem_we) mwe_o = 1;
            if (instret) begin c_o = c; ps_o = pc_sel; end
            @(posedge clk); #1;
            if (c_o > 0) break;
        end
        mem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 1; opcode = 7'h13;
        #3;
        checks++; if ({ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, instret, illegal, state} !== '0) begin failures++; $display("FAIL reset_outputs_zero got mem_req=%b state=%0d", mem_req, state); end
        mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #2;
        checks++; if (state !== 3'd0 || mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_first_fetch got state=%0d mem_req=%b exp state=0 mem_req=1", state, mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        opcode = 7'h13; mem_ready = 1;
        #2;
        checks++; if (state !== 3'd0 || ir_we !== 1'b1) begin failures++; $display("FAIL addi_fetch got state=%0d ir_we=%b exp 0/1", state, ir_we); end
        @(posedge clk); #3;
        checks++; if (state !== 3'd1 || {ir_we, pc_we, mem_req, rf_we} !== 4'b0) begin failures++; $display("FAIL addi_decode got state=%0d strobes=%b", state, {ir_we, pc_we, mem_req, rf_we}); end
        @(posedge clk); #3;
        checks++; if (state !== 3'd2 || alu_b_sel !== 1'b1 || alu_op !== 2'd2 || alu_a_sel !== 2'd0) begin failures++; $display("FAIL addi_exec got state=%0d a=%0d b=%0d op=%0d exp 2/0/1/2", state, alu_a_sel, alu_b_sel, alu_op); end
        @(posedge clk); #3;
        checks++; if (state !== 3'd4 || rf_we !== 1'b1 || wb_sel !== 2'd0 || pc_sel !== 2'd0 || instret !== 1'b1) begin failures++; $display("FAIL addi_wb got state=%0d rf_we=%b wb=%0d ps=%0d instret=%b", state, rf_we, wb_sel, pc_sel, instret); end
        @(posedge clk); #3;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL addi_back_to_fetch got state=%0d exp 0", state); end
        mem_ready = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_waits();
        run(7'h03, 0, 3, 2, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL lw_latency got=%0d exp=10", cyc); end
        checks++; if (unst !== 1'b0) begin failures++; $display("FAIL lw_handshake_stable got unstable=%b exp 0", unst); end
        checks++; if (rf !== 1'b1 || wb !== 2'd1 || mwe !== 1'b0) begin failures++; $display("FAIL lw_wb got rf=%b wb=%0d mem_we=%b exp 1/1/0", rf, wb, mwe); end
        checks++; if ({ea, eb, eo} !== {2'd0, 1'b1, 2'd0}) begin failures++; $display("FAIL lw_alu got a=%0d b=%0d op=%0d exp 0/1/0", ea, eb, eo); end
        run(7'h03, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL lw_latency_nowait got=%0d exp=5", cyc); end
    endtask

    task automatic test_branch();
        run(7'h63, 1, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 3 || ps !== 2'd1 || rf !== 1'b0) begin failures++; $display("FAIL beq_taken got cyc=%0d pc_sel=%0d rf=%b exp 3/1/0", cyc, ps, rf); end
        checks++; if ({ea, eb, eo} !== {2'd0, 1'b0, 2'd1}) begin failures++; $display("FAIL beq_alu got a=%0d b=%0d op=%0d exp 0/0/1", ea, eb, eo); end
        run(7'h63, 0, 1, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || ps !== 2'd0 || rf !== 1'b0) begin failures++; $display("FAIL beq_not_taken got cyc=%0d pc_sel=%0d rf=%b exp 4/0/0", cyc, ps, rf); end
    endtask

    task automatic test_jumps_store();
        run(7'h6F, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || rf !== 1'b1 || wb !== 2'd2 || ps !== 2'd1) begin failures++; $display("FAIL jal got cyc=%0d rf=%b wb=%0d ps=%0d exp 4/1/2/1", cyc, rf, wb, ps); end
        run(7'h67, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || rf !== 1'b1 || wb !== 2'd2 || ps !== 2'd2) begin failures++; $display("FAIL jalr got cyc=%0d rf=%b wb=%0d ps=%0d exp 4/1/2/2", cyc, rf, wb, ps); end
        run(7'h23, 0, 0, 2, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 6 || mwe !== 1'b1 || rf !== 1'b0 || ps !== 2'd0 || unst !== 1'b0) begin failures++; $display("FAIL sw got cyc=%0d mem_we=%b rf=%b ps=%0d unst=%b exp 6/1/0/0/0", cyc, mwe, rf, ps, unst); end
    endtask

    task automatic test_back_to_back();
        run(7'h37, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || {ea, eb, eo} !== {2'd2, 1'b1, 2'd0} || wb !== 2'd0) begin failures++; $display("FAIL lui got cyc=%0d a=%0d b=%0d op=%0d wb=%0d", cyc, ea, eb, eo, wb); end
        run(7'h17, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || {ea, eb, eo} !== {2'd1, 1'b1, 2'd0}) begin failures++; $display("FAIL auipc got cyc=%0d a=%0d b=%0d op=%0d", cyc, ea, eb, eo); end
        run(7'h33, 0, 0, 0, cyc, rf, wb, ps, mwe, unst, ea, eb, eo);
        checks++; if (cyc !== 4 || {ea, eb, eo} !== {2'd0, 1'b0, 2'd2} || rf !== 1'b1) begin failures++; $display("FAIL r_type got cyc=%0d a=%0d b=%0d op=%0d rf=%b", cyc, ea, eb, eo, rf); end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [2];
        int reqs;
        ops[0] = 7'h7F;
        ops[1] = 7'h00;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k]; mem_ready = 1;
            @(posedge clk); @(posedge clk); #3;
            checks++; if (state !== 3'd7 || illegal !== 1'b1) begin failures++; $display("FAIL illegal_halt op=%h got state=%0d illegal=%b exp 7/1", ops[k], state, illegal); end
            reqs = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1 mem_ready = i[0];
                #2 if (mem_req) reqs++;
            end
            checks++; if (reqs !== 0 || illegal !== 1'b1 || state !== 3'd7) begin failures++; $display("FAIL illegal_sticky op=%h got reqs=%0d illegal=%b state=%0d", ops[k], reqs, illegal, state); end
            mem_ready = 0;
            rst = 1;
            #1;
            checks++; if (illegal !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL illegal_rst_clear got illegal=%b state=%0d exp 0/0", illegal, state); end
            @(posedge clk); #1 rst = 0;
            #2;
            checks++; if (state !== 3'd0 || mem_req !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL illegal_refetch got state=%0d mem_req=%b illegal=%b", state, mem_req, illegal); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        opcode = 7'h23; mem_ready = 1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 0;
        #2;
        checks++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL mid_mem_setup got state=%0d mem_req=%b mem_we=%b exp 3/1/1", state, mem_req, mem_we); end
        rst = 1;
        #1;
        checks++; if (mem_req !== 1'b0 || state !== 3'd0 || pc_we !== 1'b0 || instret !== 1'b0) begin failures++; $display("FAIL mid_mem_abort got mem_req=%b state=%0d pc_we=%b instret=%b exp 0/0/0/0", mem_req, state, pc_we, instret); end
        mem_ready = 1;
        #1;
        checks++; if (instret !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL mid_mem_ready_in_rst got instret=%b mem_req=%b exp 0/0", instret, mem_req); end
        mem_ready = 0;
        @(posedge clk); #1 rst = 0;
        #2;
        checks++; if (state !== 3'd0 || mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL mid_mem_refetch got state=%0d mem_req=%b addr_sel=%b mem_we=%b", state, mem_req, addr_sel, mem_we); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_waits();
        test_branch();
        test_jumps_store();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
